// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // True when both operands are interpreted as two's-complement values.
  function automatic logic is_signed_op(funct3_e f);
    return (f == F_MUL) || (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the register file, the core and muldiv_unit.
// Handshake: an op is accepted on a rising edge where start=1, ready=1 and
// flush=0; the result is valid for exactly the single cycle in which done=1.
interface muldiv_if;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [4:0]  rd_in;
  logic        ready;
  logic        done;
  logic [4:0]  rd;
  logic [31:0] xd;
  logic        rd_en;

  modport master (
    output start, flush, funct3, x1, x2, rd_in,
    input  ready, done, rd, xd, rd_en
  );

  modport slave (
    input  start, flush, funct3, x1, x2, rd_in,
    output ready, done, rd, xd, rd_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, on magnitudes with a final sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  muldiv_if.slave bus,
  output state_e dbg_state_o
);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  funct3_e         op_q, op_d;
  logic [4:0]      rd_lat_q, rd_lat_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [63:0]     acc_q, acc_d;
  logic [XLEN-1:0] xd_q, xd_d;
  logic [4:0]      rd_q, rd_d;

  funct3_e         f_in;
  logic            x1_neg, x2_neg, accept, div_zero;
  logic [XLEN-1:0] x1_mag, x2_mag, divz_res;

  assign f_in     = funct3_e'(bus.funct3);
  assign x1_neg   = (is_signed_op(f_in) || f_in == F_MULHSU) && bus.x1[31];
  assign x2_neg   = is_signed_op(f_in) && bus.x2[31];
  assign x1_mag   = x1_neg ? -bus.x1 : bus.x1;
  assign x2_mag   = x2_neg ? -bus.x2 : bus.x2;
  assign accept   = bus.start && bus.ready && !bus.flush;
  assign div_zero = f_in[2] && (bus.x2 == '0);
  assign divz_res = f_in[1] ? bus.x1 : '1;

  // acc_q holds {product high, multiplier} for MUL, {remainder, quotient} for DIV.
  logic [32:0]     mul_sum, div_sh, div_diff;
  logic [63:0]     mul_next, div_next, prod_fix;
  logic [XLEN-1:0] mul_res, div_res, quo_fix, rem_fix;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign div_sh   = acc_q[63:31];
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_next = div_diff[32] ? {div_sh[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  // Sign flags are only ever set for signed operands, so no op check here.
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -mul_next : mul_next;
  assign mul_res  = (op_q == F_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  assign quo_fix  = (a_neg_q ^ b_neg_q) ? -div_next[31:0] : div_next[31:0];
  assign rem_fix  = a_neg_q ? -div_next[63:32] : div_next[63:32];
  assign div_res  = op_q[1] ? rem_fix : quo_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_lat_d = rd_lat_q;
    b_d      = b_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    acc_d    = acc_q;
    xd_d     = xd_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = f_in;
          rd_lat_d = bus.rd_in;
          b_d      = x2_mag;
          a_neg_d  = x1_neg;
          b_neg_d  = x2_neg;
          cnt_d    = 5'd31;
          acc_d    = {32'd0, x1_mag};
          if (div_zero) begin
            state_d = DONE;
            xd_d    = divz_res;
            rd_d    = bus.rd_in;
          end else begin
            state_d = f_in[2] ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == MUL) ? mul_next : div_next;
        if (cnt_q == 5'd0) begin
          state_d = DONE;
          xd_d    = (state_q == MUL) ? mul_res : div_res;
          rd_d    = rd_lat_q;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A kill drops the in-flight op without touching the visible result.
    if (bus.flush && state_q != IDLE) begin
      state_d = IDLE;
      xd_d    = xd_q;
      rd_d    = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= F_MUL;
      rd_lat_q <= '0;
      b_q      <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      acc_q    <= '0;
      xd_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_lat_q <= rd_lat_d;
      b_q      <= b_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      acc_q    <= acc_d;
      xd_q     <= xd_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.ready   = (state_q == IDLE) && !reset;
  assign bus.done    = (state_q == DONE) && !bus.flush && !reset;
  assign bus.rd_en   = bus.done;
  assign bus.xd      = xd_q;
  assign bus.rd      = rd_q;
  assign dbg_state_o = state_q;

endmodule
